// File: rtl/urng_stream.sv
// urng_stream: uniform random-number source for the Monte Carlo Hawkes
// simulator. A 23-bit maximal-length LFSR (x^23 + x^18 + 1) advances 8 steps
// per clock. Loading a seed discards WARMUP advances. After that, 8-bit
// samples stream out through a 2-entry FIFO with a valid/ready handshake.
//
// Ports:
//   clk    in   system clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   load   in   single-cycle strobe: capture seed, restart the stream
//   seed   in   23-bit run seed (zero is replaced by 23'h000001)
//   u      out  8-bit uniform sample (u/256), head of the FIFO
//   valid  out  FIFO head holds a sample
//   ready  in   consumer accepts u on an edge with valid & ready
//   busy   out  high while warming up
//   count  out  samples accepted since the last load, saturating at FFFF
//
// Parameter WARMUP (0..255): number of discarded 8-step advances after load.
module urng_stream #(
  parameter int unsigned WARMUP = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [22:0] seed,
  output logic [7:0]  u,
  output logic        valid,
  input  logic        ready,
  output logic        busy,
  output logic [15:0] count
);

  typedef enum logic [1:0] {
    IDLE,
    WARM,
    RUN
  } state_e;

  // Index of the final warm-up advance. It is unused when WARMUP is 0,
  // because load then goes straight to RUN.
  localparam logic [7:0] WARM_LAST = (WARMUP == 0) ? 8'd0 : 8'(WARMUP - 1);

  state_e      state_q, state_d;
  logic [22:0] lfsr_q, lfsr_d;
  logic [7:0]  warm_q, warm_d;
  logic [7:0]  buf0_q, buf0_d;  // head entry, drives u
  logic [7:0]  buf1_q, buf1_d;
  logic [1:0]  occ_q, occ_d;
  logic [15:0] count_q, count_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;

  logic [22:0] lfsr_next;
  logic [7:0]  sample;
  logic        pop;
  logic        push;

  // Eight unrolled Fibonacci steps. The oldest of the eight new bits ends
  // up in bit 7.
  function automatic logic [22:0] advance(input logic [22:0] s);
    logic [22:0] t;
    t = s;
    for (int unsigned i = 0; i < 8; i++) begin
      t = {t[21:0], t[22] ^ t[17]};
    end
    return t;
  endfunction

  always_comb begin
    state_d   = state_q;
    lfsr_d    = lfsr_q;
    warm_d    = warm_q;
    buf0_d    = buf0_q;
    buf1_d    = buf1_q;
    occ_d     = occ_q;
    count_d   = count_q;
    push      = 1'b0;

    lfsr_next = advance(lfsr_q);
    sample    = lfsr_next[7:0];
    pop       = (occ_q != 2'd0) && ready;

    if (load) begin
      // Load wins over any push or pop on the same edge. A sample being
      // offered is dropped and is not counted.
      state_d = (WARMUP == 0) ? RUN : WARM;
      lfsr_d  = (seed == 23'd0) ? 23'h000001 : seed;
      warm_d  = '0;
      buf0_d  = '0;
      buf1_d  = '0;
      occ_d   = '0;
      count_d = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        WARM: begin
          lfsr_d = lfsr_next;
          warm_d = warm_q + 8'd1;
          if (warm_q == WARM_LAST) begin
            state_d = RUN;
          end
        end
        RUN: begin
          // The LFSR advances only when a push happens. This keeps the
          // sample sequence independent of consumer stalls.
          push = (occ_q != 2'd2) || pop;
          if (push) begin
            lfsr_d = lfsr_next;
          end
        end
        default: state_d = IDLE;
      endcase

      unique case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) begin
            buf0_d = sample;
          end else begin
            buf1_d = sample;
          end
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          buf0_d = buf1_q;
          occ_d  = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            buf0_d = sample;
          end else begin
            buf0_d = buf1_q;
            buf1_d = sample;
          end
        end
        default: ;
      endcase

      if (pop && (count_q != 16'hFFFF)) begin
        count_d = count_q + 16'd1;
      end
    end

    busy_d  = (state_d == WARM);
    valid_d = (occ_d != 2'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= 23'h000001;
      warm_q  <= '0;
      buf0_q  <= '0;
      buf1_q  <= '0;
      occ_q   <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      warm_q  <= warm_d;
      buf0_q  <= buf0_d;
      buf1_q  <= buf1_d;
      occ_q   <= occ_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign u     = buf0_q;
  assign valid = valid_q;
  assign busy  = busy_q;
  assign count = count_q;

endmodule

// File: tb/tb_urng_stream.sv
module tb_urng_stream;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_load = 1'b0, a_ready = 1'b0;
  logic [22:0] a_seed = '0;
  logic [7:0]  a_u;
  logic        a_valid, a_busy;
  logic [15:0] a_count;

  logic        b_load = 1'b0, b_ready = 1'b0;
  logic [22:0] b_seed = '0;
  logic [7:0]  b_u;
  logic        b_valid, b_busy;
  logic [15:0] b_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  urng_stream #(.WARMUP(0)) ua (
    .clk(clk), .rst_n(rst_n), .load(a_load), .seed(a_seed), .u(a_u),
    .valid(a_valid), .ready(a_ready), .busy(a_busy), .count(a_count)
  );

  urng_stream #(.WARMUP(32)) ub (
    .clk(clk), .rst_n(rst_n), .load(b_load), .seed(b_seed), .u(b_u),
    .valid(b_valid), .ready(b_ready), .busy(b_busy), .count(b_count)
  );

  // Reference model: the LFSR output is the bit sequence b[n] = b[n-23] ^ b[n-18].
  // It is seeded with the 23 seed bits, oldest (seed[22]) first. Sample j is
  // the 8 bits generated after the seed, starting at bit 23+8j, with the
  // first generated bit as the MSB.
  localparam int NREF = 200;
  bit         seqb  [0:23+8*NREF-1];
  logic [7:0] ref_s [0:NREF-1];
  logic [7:0] got[$];

  task automatic fill_ref(input logic [22:0] sd);
    logic [22:0] s;
    s = (sd == 23'd0) ? 23'd1 : sd;
    for (int i = 0; i < 23; i++) seqb[i] = s[22-i];
    for (int n = 23; n < 23 + 8*NREF; n++) seqb[n] = seqb[n-23] ^ seqb[n-18];
    for (int j = 0; j < NREF; j++)
      for (int b = 0; b < 8; b++) ref_s[j][7-b] = seqb[23 + 8*j + b];
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Run the consumer on instance A until `want` samples have been collected.
  task automatic consume(input int want, input bit rnd);
    int cyc;
    cyc = 0;
    while (got.size() < want && cyc < 4000) begin
      a_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (a_valid && a_ready) got.push_back(a_u);
      tick();
      cyc++;
    end
    chk("consume_budget", 32'(got.size()), 32'(want));
  endtask

  // WARMUP=32 instance. An optional earlier load, `pre` cycles before,
  // checks that a restart from WARM or RUN behaves cleanly.
  task automatic warm_check(input logic [22:0] sd, input int pre);
    int lat, nbusy;
    b_ready = 1'b1;
    if (pre > 0) begin
      b_seed = 23'($urandom);
      b_load = 1'b1;
      tick();
      b_load = 1'b0;
      repeat (pre) tick();
    end
    fill_ref(sd);
    b_seed = sd;
    b_load = 1'b1;
    tick();
    b_load = 1'b0;
    chk("warm_busy_at_load", 32'(b_busy), 32'd1);
    chk("warm_valid_at_load", 32'(b_valid), 32'd0);
    lat = 0;
    nbusy = b_busy ? 1 : 0;
    while (!b_valid && lat < 200) begin
      tick();
      lat++;
      if (b_busy) nbusy++;
    end
    chk("warm_latency", 32'(lat), 32'd33);
    chk("warm_busy_cycles", 32'(nbusy), 32'd32);
    chk("warm_first_sample", 32'(b_u), 32'(ref_s[32]));
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("warm_stream", 32'(b_u), 32'(ref_s[32+i]));
    end
  endtask

  typedef struct {
    logic [22:0] seed;
    int          n;
    logic [23:0] e;   // expected samples, first in bits 23:16
  } vec_t;

  vec_t tbl[3];

  initial begin
    tbl[0] = '{23'h000001, 3, 24'h000042};
    tbl[1] = '{23'h000000, 3, 24'h000042};
    tbl[2] = '{23'h400000, 2, 24'h800000};

    // Reset state
    repeat (3) tick();
    chk("rst_u", 32'(a_u), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_busy", 32'(a_busy | b_busy), 32'd0);
    chk("rst_count", 32'(a_count), 32'd0);
    rst_n = 1'b1;
    tick();

    // Known sequences, WARMUP=0
    for (int t = 0; t < 3; t++) begin
      logic [23:0] ev;
      ev = tbl[t].e;
      a_seed  = tbl[t].seed;
      a_ready = 1'b1;
      a_load  = 1'b1;
      tick();
      a_load = 1'b0;
      chk("tbl_valid_after_load", 32'(a_valid), 32'd0);
      chk("tbl_busy_w0", 32'(a_busy), 32'd0);
      for (int i = 0; i < tbl[t].n; i++) begin
        tick();
        chk("tbl_valid", 32'(a_valid), 32'd1);
        chk("tbl_sample", 32'(a_u), 32'(ev[23-8*i -: 8]));
      end
      tick();
      chk("tbl_count", 32'(a_count), 32'(tbl[t].n));
    end

    // Backpressure, then random ready checked against the model
    fill_ref(23'd1);
    a_ready = 1'b0;
    a_seed  = 23'd1;
    a_load  = 1'b1;
    tick();
    a_load = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 32'(a_valid), 32'd1);
      chk("stall_u", 32'(a_u), 32'd0);
      chk("stall_count", 32'(a_count), 32'd0);
    end
    got.delete();
    consume(3, 1'b0);
    chk("bp_s0", 32'(got[0]), 32'h00);
    chk("bp_s1", 32'(got[1]), 32'h00);
    chk("bp_s2", 32'(got[2]), 32'h42);
    consume(100, 1'b1);
    for (int i = 0; i < 100; i++) chk("bp_stream", 32'(got[i]), 32'(ref_s[i]));
    chk("bp_count", 32'(a_count), 32'd100);
    a_ready = 1'b0;

    // Warm-up, plus restarts from WARM and from RUN
    warm_check(23'(32'h1), 0);
    warm_check(23'($urandom), 0);
    warm_check(23'($urandom), 10);
    warm_check(23'($urandom), 40);

    // Restart mid-RUN on an accepting edge
    a_seed  = 23'd5;
    a_ready = 1'b1;
    a_load  = 1'b1;
    tick();
    a_load = 1'b0;
    repeat (4) tick();
    chk("restart_pre_valid", 32'(a_valid), 32'd1);
    a_seed = 23'd1;
    a_load = 1'b1;
    tick();
    a_load = 1'b0;
    chk("restart_count", 32'(a_count), 32'd0);
    chk("restart_valid", 32'(a_valid), 32'd0);
    tick();
    chk("restart_s0", 32'(a_u), 32'h00);
    tick();
    chk("restart_s1", 32'(a_u), 32'h00);
    tick();
    chk("restart_s2", 32'(a_u), 32'h42);
    tick();
    chk("restart_count3", 32'(a_count), 32'd3);

    // Asynchronous reset mid-RUN, then stay idle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(a_valid), 32'd0);
    chk("async_rst_count", 32'(a_count), 32'd0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_after_rst", {7'd0, a_u, a_valid, a_busy, a_count}, 32'd0);
    end

    // Saturation: one accept per cycle with ready held high
    a_seed  = 23'($urandom);
    a_ready = 1'b1;
    a_load  = 1'b1;
    tick();
    a_load = 1'b0;
    repeat (65535) tick();
    chk("sat_fffe", 32'(a_count), 32'hFFFE);
    tick();
    chk("sat_ffff", 32'(a_count), 32'hFFFF);
    repeat (5) tick();
    chk("sat_hold", 32'(a_count), 32'hFFFF);
    chk("sat_valid", 32'(a_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
